// File: rtl/score_event_pacer.sv
// score_event_pacer: queues multi-point hit events from the game logic and
// replays them as evenly paced add_cube pulses (HIGH_CYC high, LOW_CYC low)
// so the downstream score display's edge detector counts each point once.
// Optional build macro PACE_STAT_EN adds the drop_cnt statistics output.
module score_event_pacer #(
  parameter int PEND_W   = 4,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic              hit_valid,
  input  logic [2:0]        hit_count,
  input  logic              clear,
  output logic              add_cube,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef PACE_STAT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int MAX_PEND = (1 << PEND_W) - 1;
  localparam int SUM_W    = PEND_W + 2;
  localparam int PH_MAX   = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0]  LOW_LAST  = PH_W'(LOW_CYC - 1);
  localparam logic [SUM_W-1:0] MAX_SUM   = SUM_W'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PEND_W-1:0]  pending_d;
  logic               overflow_d;
  logic               add_cube_d;
  logic               busy_d;
  logic               start;
  logic [SUM_W-1:0]   inc;
  logic [SUM_W-1:0]   avail;
  logic [SUM_W-1:0]   next_sum;
  logic               saturate;
`ifdef PACE_STAT_EN
  logic [8:0]         drop_sum;
  logic [7:0]         drop_cnt_d;
`endif

  // Next-state logic: pulse pacing, queue arithmetic with saturation, and the
  // registered status outputs derived from the state being entered.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    start      = 1'b0;
    pending_d  = pending;
    overflow_d = overflow;

    // A strobe coinciding with clear is discarded, and clear empties the queue,
    // so nothing is available to start while clear is high.
    inc   = (hit_valid && !clear) ? SUM_W'(hit_count) : '0;
    avail = clear ? '0 : (SUM_W'(pending) + inc);

    case (state_q)
      ST_IDLE: begin
        if (avail != '0) begin
          start   = 1'b1;
          state_d = ST_HIGH;
          phase_d = '0;
        end
      end
      ST_HIGH: begin
        // clear cuts the pulse short but still enters a full low phase.
        if (clear || (phase_q == HIGH_LAST)) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_LOW: begin
        if (phase_q == LOW_LAST) begin
          phase_d = '0;
          if (avail != '0) begin
            start   = 1'b1;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    next_sum = avail - (start ? SUM_W'(1) : '0);
    saturate = !clear && (next_sum > MAX_SUM);

    if (clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (saturate) begin
      pending_d  = PEND_W'(MAX_PEND);
      overflow_d = 1'b1;
    end else begin
      pending_d  = next_sum[PEND_W-1:0];
    end

    add_cube_d = (state_d == ST_HIGH);
    busy_d     = (state_d != ST_IDLE) || (pending_d != '0);

`ifdef PACE_STAT_EN
    drop_sum   = {1'b0, drop_cnt} + 9'(next_sum - MAX_SUM);
    drop_cnt_d = drop_cnt;
    if (clear) begin
      drop_cnt_d = '0;
    end else if (saturate) begin
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif
  end

  // State and output registers; reset cuts any pulse in progress immediately.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      add_cube <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
`ifdef PACE_STAT_EN
      drop_cnt <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      add_cube <= add_cube_d;
      busy     <= busy_d;
      pending  <= pending_d;
      overflow <= overflow_d;
`ifdef PACE_STAT_EN
      drop_cnt <= drop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_score_event_pacer.sv
// tb_score_event_pacer: self-checking bench for score_event_pacer using a
// vector table, hand-written corner sequences and a randomized run against
// a time-based reference model. Honours PACE_STAT_EN when defined.
module tb_score_event_pacer;

  localparam int PEND_W   = 4;
  localparam int HIGH_CYC = 4;
  localparam int LOW_CYC  = 4;
  localparam int MAX_PEND = (1 << PEND_W) - 1;

  logic              CLK_50M = 1'b0;
  logic              RST = 1'b1;
  logic              hit_valid = 1'b0;
  logic [2:0]        hit_count = 3'd0;
  logic              clear = 1'b0;
  logic              add_cube;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
`ifdef PACE_STAT_EN
  logic [7:0]        drop_cnt;
`endif

  score_event_pacer #(
    .PEND_W(PEND_W),
    .HIGH_CYC(HIGH_CYC),
    .LOW_CYC(LOW_CYC)
  ) dut (
    .CLK_50M(CLK_50M),
    .RST(RST),
    .hit_valid(hit_valid),
    .hit_count(hit_count),
    .clear(clear),
    .add_cube(add_cube),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
`ifdef PACE_STAT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // 50 MHz clock
  always #10 CLK_50M = ~CLK_50M;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: absolute edge numbers of the current pulse's falling
  // edge and of the earliest edge a new pulse may start.
  int cyc = 0;
  int m_pend, m_ovf, m_drops;
  int fall_edge, free_edge;

  typedef struct {
    logic       hv;
    logic [2:0] hc;
    logic       clr;
    int         e_add;
    int         e_pend;
    int         e_busy;
    int         e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic modelReset();
    m_pend    = 0;
    m_ovf     = 0;
    m_drops   = 0;
    fall_edge = cyc;
    free_edge = cyc;
  endtask

  task automatic modelEdge(input logic hv, input logic [2:0] hc, input logic clr);
    int  n;
    int  inc;
    int  avail;
    int  nxt;
    bit  start;
    cyc++;
    n   = cyc;
    inc = (hv && !clr) ? int'(hc) : 0;
    if (clr) begin
      m_pend  = 0;
      m_ovf   = 0;
      m_drops = 0;
      if (n < fall_edge) begin
        fall_edge = n;
        free_edge = n + LOW_CYC;
      end
    end
    avail = clr ? 0 : m_pend + inc;
    start = (n >= free_edge) && (avail > 0);
    if (start) begin
      fall_edge = n + HIGH_CYC;
      free_edge = n + HIGH_CYC + LOW_CYC;
    end
    if (!clr) begin
      nxt = avail - (start ? 1 : 0);
      if (nxt > MAX_PEND) begin
        m_drops = (m_drops + nxt - MAX_PEND > 255) ? 255 : m_drops + nxt - MAX_PEND;
        m_pend  = MAX_PEND;
        m_ovf   = 1;
      end else begin
        m_pend = nxt;
      end
    end
  endtask

  function automatic int modelAdd();
    return (cyc < fall_edge) ? 1 : 0;
  endfunction

  function automatic int modelBusy();
    return ((cyc < free_edge) || (m_pend != 0)) ? 1 : 0;
  endfunction

  // Drive one cycle of inputs, clock it, update the model, sample at edge+1.
  task automatic applyStimulus(input logic hv, input logic [2:0] hc, input logic clr);
    hit_valid = hv;
    hit_count = hc;
    clear     = clr;
    @(posedge CLK_50M);
    modelEdge(hv, hc, clr);
    #1;
    hit_valid = 1'b0;
    hit_count = 3'd0;
    clear     = 1'b0;
  endtask

  task automatic drainIdle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      n++;
    end
    checkOutput(name, int'(busy), 0);
  endtask

  task automatic addVec(input logic hv, input logic [2:0] hc, input logic clr,
                        input int a, input int p, input int b, input int o);
    vec_t v;
    v.hv = hv; v.hc = hc; v.clr = clr;
    v.e_add = a; v.e_pend = p; v.e_busy = b; v.e_ovf = o;
    vecs.push_back(v);
  endtask

  initial begin
    int rises;
    int busy_drop;
    int rise_t[4];
    int rise_p[4];
    int prev;
    int stuck;
    logic       hv;
    logic [2:0] hc;
    logic       clr;

    // Single point from idle, a hit_count=0 no-op, then accumulation in HIGH
    // followed by a back-to-back pulse.
    addVec(1'b1, 3'd1, 1'b0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) addVec(1'b0, 3'd0, 1'b0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) addVec(1'b0, 3'd0, 1'b0, 0, 0, 1, 0);
    addVec(1'b0, 3'd0, 1'b0, 0, 0, 0, 0);
    addVec(1'b1, 3'd0, 1'b0, 0, 0, 0, 0);
    addVec(1'b1, 3'd2, 1'b0, 1, 1, 1, 0);
    addVec(1'b1, 3'd1, 1'b0, 1, 2, 1, 0);
    addVec(1'b1, 3'd0, 1'b0, 1, 2, 1, 0);
    addVec(1'b0, 3'd0, 1'b0, 1, 2, 1, 0);
    for (int i = 0; i < 4; i++) addVec(1'b0, 3'd0, 1'b0, 0, 2, 1, 0);
    addVec(1'b0, 3'd0, 1'b0, 1, 1, 1, 0);

    // Reset state
    modelReset();
    repeat (3) @(posedge CLK_50M);
    #1;
    checkOutput("reset_add", int'(add_cube), 0);
    checkOutput("reset_pend", int'(pending), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ovf", int'(overflow), 0);
    RST = 1'b0;
    modelReset();

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].hv, vecs[i].hc, vecs[i].clr);
      checkOutput($sformatf("vec%0d_add", i), int'(add_cube), vecs[i].e_add);
      checkOutput($sformatf("vec%0d_pend", i), int'(pending), vecs[i].e_pend);
      checkOutput($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
      checkOutput($sformatf("vec%0d_ovf", i), int'(overflow), vecs[i].e_ovf);
    end
    drainIdle("drain_table");

    // Three points: rises 8 cycles apart, pending 2,1,0 at each rise
    applyStimulus(1'b1, 3'd3, 1'b0);
    rises = 0;
    busy_drop = -1;
    if (add_cube) begin
      rise_t[0] = 0;
      rise_p[0] = int'(pending);
      rises = 1;
    end
    prev = int'(add_cube);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      if (add_cube && prev == 0) begin
        if (rises < 4) begin
          rise_t[rises] = i;
          rise_p[rises] = int'(pending);
        end
        rises++;
      end
      if (!busy && busy_drop < 0) busy_drop = i;
      prev = int'(add_cube);
    end
    checkOutput("three_rises", rises, 3);
    if (rises == 3) begin
      checkOutput("three_rise1_t", rise_t[1], 8);
      checkOutput("three_rise2_t", rise_t[2], 16);
      checkOutput("three_pend0", rise_p[0], 2);
      checkOutput("three_pend1", rise_p[1], 1);
      checkOutput("three_pend2", rise_p[2], 0);
    end
    checkOutput("three_busy_drop", busy_drop, 24);

    // Saturation while in HIGH: 13 pending plus 5 drops 3 points
    applyStimulus(1'b1, 3'd7, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b0);
    checkOutput("sat_pend13", int'(pending), 13);
    applyStimulus(1'b1, 3'd5, 1'b0);
    checkOutput("sat_pend", int'(pending), 15);
    checkOutput("sat_ovf", int'(overflow), 1);
    checkOutput("sat_add", int'(add_cube), 1);
`ifdef PACE_STAT_EN
    checkOutput("sat_drop", int'(drop_cnt), 3);
`endif
    rises = 0;
    prev = int'(add_cube);
    for (int i = 0; i < 200 && busy; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      if (add_cube && prev == 0) rises++;
      prev = int'(add_cube);
    end
    checkOutput("sat_further_pulses", rises, 15);
    checkOutput("sat_idle", int'(busy), 0);
    checkOutput("sat_ovf_sticky", int'(overflow), 1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("sat_clear_ovf", int'(overflow), 0);
`ifdef PACE_STAT_EN
    checkOutput("sat_clear_drop", int'(drop_cnt), 0);
`endif

    // clear in the second HIGH cycle with 6 pending, strobe in the same cycle
    applyStimulus(1'b1, 3'd7, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("clr_pre_pend", int'(pending), 6);
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("clr_add", int'(add_cube), 0);
    checkOutput("clr_pend", int'(pending), 0);
    checkOutput("clr_ovf", int'(overflow), 0);
    checkOutput("clr_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("clr_low_busy", int'(busy), 1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("clr_idle_busy", int'(busy), 0);
    stuck = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      if (add_cube) stuck++;
    end
    checkOutput("clr_no_pulse", stuck, 0);

    // Strobe in the last LOW cycle starts the next HIGH with no idle gap
    applyStimulus(1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("gap_low_add", int'(add_cube), 0);
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkOutput("gap_add", int'(add_cube), 1);
    checkOutput("gap_pend", int'(pending), 0);
    checkOutput("gap_busy", int'(busy), 1);
    drainIdle("drain_gap");

    // Reset asserted mid-pulse cuts the pulse at once
    applyStimulus(1'b1, 3'd2, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("rst_pre_add", int'(add_cube), 1);
    #4;
    RST = 1'b1;
    #1;
    checkOutput("rst_mid_add", int'(add_cube), 0);
    checkOutput("rst_mid_pend", int'(pending), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_ovf", int'(overflow), 0);
    repeat (3) @(posedge CLK_50M);
    #1;
    RST = 1'b0;
    modelReset();
    stuck = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      if (add_cube || busy) stuck++;
    end
    checkOutput("rst_after_quiet", stuck, 0);

    // Randomized run against the reference model: heavy then light traffic
    for (int i = 0; i < 600; i++) begin
      hv  = (i < 300) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      hc  = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 59) == 0);
      applyStimulus(hv, hc, clr);
      checkOutput($sformatf("rand%0d_add", i), int'(add_cube), modelAdd());
      checkOutput($sformatf("rand%0d_pend", i), int'(pending), m_pend);
      checkOutput($sformatf("rand%0d_busy", i), int'(busy), modelBusy());
      checkOutput($sformatf("rand%0d_ovf", i), int'(overflow), m_ovf);
`ifdef PACE_STAT_EN
      checkOutput($sformatf("rand%0d_drop", i), int'(drop_cnt), m_drops);
`endif
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
